// File: rtl/fetch_pkg.sv
// Shared constants and FSM encoding for the fetch/decode front stage.
// Optional macro FETCH_ILLEGAL_TRAP_EN adds the terminal HALT state.
package fetch_pkg;

  localparam logic [6:0]  OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam int unsigned INSN_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
`ifdef FETCH_ILLEGAL_TRAP_EN
    , ST_HALT
`endif
  } fetch_state_e;

  function automatic logic opcode_supported(input logic [6:0] op);
    return (op == OPC_RTYPE) || (op == OPC_LOAD);
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// Combinational split of an instruction word into its decode fields.
module instr_field_split #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned WIDTH_OP = 7
) (
  input  logic [XLEN-1:0]     ir,
  output logic [WIDTH_OP-1:0] opcode,
  output logic [4:0]          rd,
  output logic [2:0]          func3,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [WIDTH_OP-1:0] func7,
  output logic [19:0]         imm_data
);

  assign opcode   = WIDTH_OP'(ir[6:0]);
  assign rd       = ir[11:7];
  assign func3    = ir[14:12];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign func7    = WIDTH_OP'(ir[31:25]);
  assign imm_data = ir[31:12];

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front stage: PC, req/gnt/rvalid instruction fetch, IR and field decode.
// Optional macro FETCH_ILLEGAL_TRAP_EN enables illegal-opcode flagging and HALT.
module instr_fetch_decode
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     WIDTH_OP = 7,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [XLEN-1:0]     imem_rdata,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                dec_valid,
  input  logic                dec_ready,
  output logic [XLEN-1:0]     dec_pc,
  output logic [WIDTH_OP-1:0] opcode,
  output logic [4:0]          rd,
  output logic [2:0]          func3,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [WIDTH_OP-1:0] func7,
  output logic [19:0]         imm_data,
  output logic                illegal
);

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] ir, ir_n;
  logic [XLEN-1:0] dec_pc_q, dec_pc_n;
  logic            drop, drop_n;
  logic [XLEN-1:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & ~XLEN'(3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      dec_pc_q <= '0;
      drop     <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      ir       <= ir_n;
      dec_pc_q <= dec_pc_n;
      drop     <= drop_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    ir_n     = ir;
    dec_pc_n = dec_pc_q;
    drop_n   = drop;
    unique case (state)
      ST_IDLE: state_n = ST_REQ;
      ST_REQ: begin
        if (redirect_valid) pc_n = redirect_aligned;
        if (imem_gnt) begin
          state_n = ST_WAIT;
          // A grant for the old PC is already in flight; mark its data stale.
          drop_n  = redirect_valid;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) pc_n = redirect_aligned;
        if (imem_rvalid) begin
          if (drop || redirect_valid) begin
            drop_n  = 1'b0;
            state_n = ST_REQ;
          end else begin
            ir_n     = imem_rdata;
            dec_pc_n = pc;
            state_n  = ST_HOLD;
          end
        end else if (redirect_valid) begin
          drop_n = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_n    = redirect_aligned;
          state_n = ST_REQ;
        end else if (dec_ready) begin
`ifdef FETCH_ILLEGAL_TRAP_EN
          if (illegal) begin
            state_n = ST_HALT;
          end else begin
            pc_n    = pc + XLEN'(INSN_BYTES);
            state_n = ST_REQ;
          end
`else
          pc_n    = pc + XLEN'(INSN_BYTES);
          state_n = ST_REQ;
`endif
        end
      end
`ifdef FETCH_ILLEGAL_TRAP_EN
      ST_HALT: begin
        if (redirect_valid) begin
          pc_n    = redirect_aligned;
          state_n = ST_REQ;
        end
      end
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  assign imem_req  = (state == ST_REQ);
  assign imem_addr = pc;
  assign dec_valid = (state == ST_HOLD);
  assign dec_pc    = dec_pc_q;

`ifdef FETCH_ILLEGAL_TRAP_EN
  assign illegal = ((state == ST_HOLD) && !opcode_supported(7'(opcode))) ||
                   (state == ST_HALT);
`else
  assign illegal = 1'b0;
`endif

  instr_field_split #(
    .XLEN     (XLEN),
    .WIDTH_OP (WIDTH_OP)
  ) u_field_split (
    .ir       (ir),
    .opcode   (opcode),
    .rd       (rd),
    .func3    (func3),
    .rs1      (rs1),
    .rs2      (rs2),
    .func7    (func7),
    .imm_data (imm_data)
  );

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode; honours FETCH_ILLEGAL_TRAP_EN when defined.
module tb_instr_fetch_decode;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned WIDTH_OP = 7;
`ifdef FETCH_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                imem_req;
  logic [XLEN-1:0]     imem_addr;
  logic                imem_gnt;
  logic                imem_rvalid;
  logic [XLEN-1:0]     imem_rdata;
  logic                redirect_valid;
  logic [XLEN-1:0]     redirect_pc;
  logic                dec_valid;
  logic                dec_ready;
  logic [XLEN-1:0]     dec_pc;
  logic [WIDTH_OP-1:0] opcode;
  logic [4:0]          rd;
  logic [2:0]          func3;
  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic [WIDTH_OP-1:0] func7;
  logic [19:0]         imm_data;
  logic                illegal;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  instr_fetch_decode #(
    .XLEN     (XLEN),
    .WIDTH_OP (WIDTH_OP),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .opcode         (opcode),
    .rd             (rd),
    .func3          (func3),
    .rs1            (rs1),
    .rs2            (rs2),
    .func7          (func7),
    .imm_data       (imm_data),
    .illegal        (illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // All sampling and driving happens at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"},       32'(imem_req),  32'h0);
    check({tag, "_addr"},      imem_addr,      32'h0);
    check({tag, "_dec_valid"}, 32'(dec_valid), 32'h0);
    check({tag, "_illegal"},   32'(illegal),   32'h0);
    check({tag, "_opcode"},    32'(opcode),    32'h0);
    check({tag, "_rd"},        32'(rd),        32'h0);
    check({tag, "_imm"},       32'(imm_data),  32'h0);
    check({tag, "_dec_pc"},    dec_pc,         32'h0);
  endtask

  task automatic wait_req(input string tag);
    int unsigned n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    check({tag, "_req_seen"}, 32'(imem_req), 32'h1);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] word);
    wait_req("fetch");
    check("fetch_addr", imem_addr, addr);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    check("wait_no_req", 32'(imem_req), 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    sb.push_back('{pc: addr, word: word});
    step();
    imem_rvalid = 1'b0;
  endtask

  task automatic expect_decode();
    exp_t e;
    logic exp_ill;
    int unsigned n = 0;
    while (!dec_valid && n < 20) begin
      step();
      n++;
    end
    check("dec_valid_seen", 32'(dec_valid), 32'h1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'h0, 32'h1);
      return;
    end
    e = sb.pop_front();
    exp_ill = TRAP && !(e.word[6:0] == 7'b0110011 || e.word[6:0] == 7'b0000011);
    check("dec_pc",  dec_pc,           e.pc);
    check("opcode",  32'(opcode),      32'(e.word[6:0]));
    check("rd",      32'(rd),          32'(e.word[11:7]));
    check("func3",   32'(func3),       32'(e.word[14:12]));
    check("rs1",     32'(rs1),         32'(e.word[19:15]));
    check("rs2",     32'(rs2),         32'(e.word[24:20]));
    check("func7",   32'(func7),       32'(e.word[31:25]));
    check("imm",     32'(imm_data),    32'(e.word[31:12]));
    check("illegal", 32'(illegal),     32'(exp_ill));
  endtask

  task automatic consume(input int unsigned stall);
    logic [31:0] pc0;
    logic [31:0] op0;
    expect_decode();
    pc0 = dec_pc;
    op0 = 32'(opcode);
    for (int unsigned i = 0; i < stall; i++) begin
      dec_ready = 1'b0;
      step();
      check("stall_valid",  32'(dec_valid), 32'h1);
      check("stall_no_req", 32'(imem_req),  32'h0);
      check("stall_pc",     dec_pc,         pc0);
      check("stall_opcode", 32'(opcode),    op0);
    end
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    repeat (3) step();
    check_reset("rst");

    // Reset release, immediate grant, add x10,x10,x11
    rst_n = 1'b1;
    step();
    check("t1_req", 32'(imem_req), 32'h1);
    fetch(32'h0, 32'h00B50533);
    check("t1_latency", 32'(dec_valid), 32'h1);
    consume(5);

    // Redirect during WAIT discards returned data
    wait_req("t3");
    check("t3_addr", imem_addr, 32'h4);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    step();
    imem_rvalid = 1'b0;
    check("t3_no_valid", 32'(dec_valid), 32'h0);
    check("t3_req",      32'(imem_req),  32'h1);
    check("t3_addr_new", imem_addr,      32'h100);

    fetch(32'h100, 32'h0002A303);
    consume(0);
    fetch(32'h104, 32'h40B50533);

    // Redirect together with dec_ready in HOLD: redirect wins
    expect_decode();
    dec_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    dec_ready = 1'b0; redirect_valid = 1'b0;
    check("hold_redir_valid", 32'(dec_valid), 32'h0);
    check("hold_redir_addr",  imem_addr,      32'hFFFF_FFFC);

    // PC wrap
    fetch(32'hFFFF_FFFC, 32'h00C58633);
    consume(0);
    wait_req("t4");
    check("t4_wrap_addr", imem_addr, 32'h0);

    // Redirect in the same cycle as grant
    imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    imem_gnt = 1'b0; redirect_valid = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h12345678;
    step();
    imem_rvalid = 1'b0;
    check("gnt_redir_valid", 32'(dec_valid), 32'h0);
    check("gnt_redir_addr",  imem_addr,      32'h40);

    // Grant withheld, then reset mid-WAIT with a late rvalid
    for (int unsigned i = 0; i < 4; i++) begin
      check("t5_req_hold",  32'(imem_req), 32'h1);
      check("t5_addr_hold", imem_addr,     32'h40);
      step();
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    step();
    check_reset("t5_rst");
    imem_rvalid = 1'b1; imem_rdata = 32'h00B50533;
    step();
    imem_rvalid = 1'b0;
    rst_n = 1'b1;
    step();
    check("t5_restart_req",   32'(imem_req),  32'h1);
    check("t5_restart_addr",  imem_addr,      32'h0);
    check("t5_restart_valid", 32'(dec_valid), 32'h0);

    // Unsupported opcode (jal)
    fetch(32'h0, 32'h0000006F);
    expect_decode();
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
    for (int unsigned i = 0; i < 3; i++) begin
      check("halt_no_req",  32'(imem_req),  32'h0);
      check("halt_invalid", 32'(dec_valid), 32'h0);
      check("halt_illegal", 32'(illegal),   32'h1);
      step();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    check("halt_resume_req",  32'(imem_req), 32'h1);
    check("halt_resume_addr", imem_addr,     32'h80);
`else
    check("pass_illegal", 32'(illegal), 32'h0);
    wait_req("pass");
    check("pass_addr", imem_addr, 32'h4);
`endif

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
